// File: rtl/sim_exit_device_if.sv
// Store-path and console-stream signals of the simulation exit device.
// The master side is the CPU/console environment, the slave side is the device.
interface sim_exit_device_if;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_stall;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready;
  logic        isHalt;
  logic [31:0] ret_val;

  modport master (
    output wr_en, wr_addr, wr_data, cons_ready,
    input  wr_stall, cons_valid, cons_data, isHalt, ret_val
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, cons_ready,
    output wr_stall, cons_valid, cons_data, isHalt, ret_val
  );
endinterface

// File: rtl/sim_exit_device.sv
// Simulation control device: buffers console bytes written by software, and on an
// exit store (or watchdog expiry) drains the console before raising isHalt with the
// exit code. HALT is sticky until rst_n is asserted.
module sim_exit_device #(
  parameter logic [31:0] EXIT_ADDR    = 32'h8000_0000,
  parameter logic [31:0] CONS_ADDR    = 32'h8000_0002,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 500000,
  parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  sim_exit_device_if.slave   bus
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam bit          WD_EN      = (MAX_CYCLES != 0);
  localparam logic [31:0] WD_LAST    = 32'(MAX_CYCLES) - 32'd1;
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES) - 32'd1;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t      state;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] occupancy;
  logic [AW-1:0] rd_next_idx;
  logic [7:0]  head;
  logic [31:0] cycle_cnt;
  logic [31:0] idle_cnt;
  logic [31:0] ret_val_q;
  logic        halt_q;

  logic empty;
  logic full;
  logic cons_store;
  logic exit_store;
  logic push;
  logic pop;
  logic wd_expire;

  // One extra pointer bit distinguishes full from empty when the low bits match.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign occupancy   = wr_ptr - rd_ptr;
  assign rd_next_idx = rd_ptr[AW-1:0] + IDX_ONE;

  // Stores only act while running; a pop in the same cycle never frees space for a push.
  assign cons_store = (state == S_RUN) && bus.wr_en && (bus.wr_addr == CONS_ADDR);
  assign exit_store = (state == S_RUN) && bus.wr_en && (bus.wr_addr == EXIT_ADDR);
  assign push       = cons_store && !full;
  assign pop        = !empty && bus.cons_ready;
  assign wd_expire  = WD_EN && (cycle_cnt == WD_LAST);

  assign bus.wr_stall   = cons_store && full;
  assign bus.cons_valid = !empty;
  assign bus.cons_data  = head;
  assign bus.isHalt     = halt_q;
  assign bus.ret_val    = ret_val_q;

  // Console byte storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.wr_data[7:0];
    end
  end

  // FIFO pointers and a registered head byte that already holds the next entry after a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (occupancy > PTR_ONE) begin
          head <= mem[rd_next_idx];
        end else if (push) begin
          head <= bus.wr_data[7:0];
        end
      end else if (push && empty) begin
        head <= bus.wr_data[7:0];
      end
    end
  end

  // Run/drain/halt sequencing with watchdog, exit code capture and idle-cycle drain timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      cycle_cnt <= '0;
      idle_cnt  <= '0;
      ret_val_q <= '0;
      halt_q    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (exit_store) begin
            ret_val_q <= bus.wr_data;
            idle_cnt  <= '0;
            state     <= S_DRAIN;
          end else if (wd_expire) begin
            ret_val_q <= TIMEOUT_CODE;
            idle_cnt  <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!empty) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
            if (idle_cnt == DRAIN_LAST) begin
              state  <= S_HALT;
              halt_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          halt_q <= 1'b1;
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_exit_device.sv
// Self-checking bench for sim_exit_device: directed scenarios plus randomized
// episodes checked cycle by cycle against a queue-based behavioural model.
module tb_sim_exit_device;

  localparam logic [31:0] EXIT_A  = 32'h8000_0000;
  localparam logic [31:0] CONS_A  = 32'h8000_0002;
  localparam int          DEPTH   = 8;
  localparam int          DRAIN   = 4;
  localparam int          MAXC    = 100;
  localparam logic [31:0] TO_CODE = 32'hDEAD_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cycle_no;

  sim_exit_device_if bus ();

  sim_exit_device #(
    .EXIT_ADDR    (EXIT_A),
    .CONS_ADDR    (CONS_A),
    .DEPTH        (DEPTH),
    .DRAIN_CYCLES (DRAIN),
    .MAX_CYCLES   (MAXC),
    .TIMEOUT_CODE (TO_CODE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release: cycle k is the one ending at the k-th posedge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle_no <= 0;
    else        cycle_no <= cycle_no + 1;
  end

  // Behavioural model state
  logic [7:0]  mq[$];
  bit          m_stop;
  bit          m_halt;
  int          m_run;
  int          m_idle;
  logic [31:0] m_ret;

  function automatic void model_reset();
    mq.delete();
    m_stop = 0;
    m_halt = 0;
    m_run  = 0;
    m_idle = 0;
    m_ret  = '0;
  endfunction

  // Advances the model by one clock using the inputs currently on the bus.
  function automatic void model_step();
    int n;
    bit was_stopped;
    bit is_cons;
    bit is_exit;
    n           = mq.size();
    was_stopped = m_stop;
    is_cons     = bus.wr_en && (bus.wr_addr == CONS_A);
    is_exit     = bus.wr_en && (bus.wr_addr == EXIT_A);
    if (!m_stop) begin
      if (is_exit) begin
        m_ret = bus.wr_data; m_stop = 1; m_idle = 0;
      end else if (m_run == MAXC - 1) begin
        m_ret = TO_CODE; m_stop = 1; m_idle = 0;
      end
      m_run++;
    end else if (!m_halt) begin
      if (n > 0) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == DRAIN) m_halt = 1;
      end
    end
    if (n > 0 && bus.cons_ready) void'(mq.pop_front());
    if (!was_stopped && is_cons && n < DEPTH) mq.push_back(bus.wr_data[7:0]);
  endfunction

  task automatic set_in(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bus.wr_en      = we;
    bus.wr_addr    = a;
    bus.wr_data    = d;
    bus.cons_ready = rdy;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    assert_reset();
    checks += 5;
    if (bus.isHalt !== 1'b0) begin errors++; $display("[TB] FAIL reset_isHalt got=%b exp=0", bus.isHalt); end
    if (bus.ret_val !== 32'h0) begin errors++; $display("[TB] FAIL reset_ret_val got=%h exp=0", bus.ret_val); end
    if (bus.cons_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cons_valid got=%b exp=0", bus.cons_valid); end
    if (bus.cons_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_cons_data got=%h exp=0", bus.cons_data); end
    if (bus.wr_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_stall got=%b exp=0", bus.wr_stall); end
    release_reset();
  endtask

  task automatic test_hello();
    logic [7:0] got[$];
    logic [7:0] exp_b[2];
    int last_pop;
    int halt_at;
    exp_b[0] = 8'h48;
    exp_b[1] = 8'h69;
    last_pop = -1;
    halt_at  = -1;
    assert_reset();
    release_reset();
    for (int k = 0; k < 40; k++) begin
      if (k == 0)      set_in(1'b1, CONS_A, 32'h48, 1'b1);
      else if (k == 1) set_in(1'b1, CONS_A, 32'h69, 1'b1);
      else if (k == 2) set_in(1'b1, EXIT_A, 32'd42, 1'b1);
      else             set_in(1'b0, '0, '0, 1'b1);
      #1;
      if (bus.cons_valid && bus.cons_ready) begin got.push_back(bus.cons_data); last_pop = cycle_no; end
      if (bus.isHalt === 1'b1 && halt_at < 0) halt_at = cycle_no;
      @(negedge clk);
    end
    checks += 4;
    if (got.size() != 2) begin errors++; $display("[TB] FAIL hello_count got=%0d exp=2", got.size()); end
    for (int i = 0; i < got.size() && i < 2; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("[TB] FAIL hello_byte%0d got=%h exp=%h", i, got[i], exp_b[i]); end
    end
    if (bus.ret_val !== 32'd42) begin errors++; $display("[TB] FAIL hello_ret_val got=%h exp=%h", bus.ret_val, 32'd42); end
    if (halt_at < 0) begin errors++; $display("[TB] FAIL hello_halt_timeout got=none exp=isHalt"); end
    if (halt_at - last_pop != 1 + DRAIN) begin
      errors++; $display("[TB] FAIL hello_latency got=%0d exp=%0d", halt_at - last_pop, 1 + DRAIN);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] b[9];
    logic [7:0] got[$];
    assert_reset();
    release_reset();
    for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, CONS_A, {24'h0, b[k]}, 1'b0);
      #1;
      checks++;
      if (bus.wr_stall !== 1'b0) begin errors++; $display("[TB] FAIL full_fill_stall%0d got=%b exp=0", k, bus.wr_stall); end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, CONS_A, {24'h0, b[8]}, k == 2);
      #1;
      checks++;
      if (bus.wr_stall !== 1'b1) begin errors++; $display("[TB] FAIL full_stall%0d got=%b exp=1", k, bus.wr_stall); end
      if (bus.cons_valid && bus.cons_ready) got.push_back(bus.cons_data);
      @(negedge clk);
    end
    set_in(1'b1, CONS_A, {24'h0, b[8]}, 1'b0);
    #1;
    checks++;
    if (bus.wr_stall !== 1'b0) begin errors++; $display("[TB] FAIL full_retry_accept got=%b exp=0", bus.wr_stall); end
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      set_in(1'b0, '0, '0, 1'b1);
      #1;
      if (bus.cons_valid && bus.cons_ready) got.push_back(bus.cons_data);
      @(negedge clk);
    end
    checks++;
    if (got.size() != 9) begin errors++; $display("[TB] FAIL full_count got=%0d exp=9", got.size()); end
    for (int i = 0; i < got.size() && i < 9; i++) begin
      checks++;
      if (got[i] !== b[i]) begin errors++; $display("[TB] FAIL full_order%0d got=%h exp=%h", i, got[i], b[i]); end
    end
  endtask

  // Runs until isHalt (bounded); exit_cycle < 0 means no exit store is issued.
  task automatic run_to_halt(input int exit_cycle, input logic [31:0] exit_data, output int halt_at);
    halt_at = -1;
    for (int k = 0; k < 150 && halt_at < 0; k++) begin
      if (k == exit_cycle) set_in(1'b1, EXIT_A, exit_data, 1'b0);
      else                 set_in(1'b0, '0, '0, 1'b0);
      #1;
      if (bus.isHalt === 1'b1) halt_at = cycle_no;
      @(negedge clk);
    end
  endtask

  task automatic test_watchdog();
    int halt_at;
    assert_reset();
    release_reset();
    run_to_halt(-1, '0, halt_at);
    checks += 2;
    if (halt_at != MAXC + DRAIN) begin errors++; $display("[TB] FAIL wd_halt_cycle got=%0d exp=%0d", halt_at, MAXC + DRAIN); end
    if (bus.ret_val !== TO_CODE) begin errors++; $display("[TB] FAIL wd_ret_val got=%h exp=%h", bus.ret_val, TO_CODE); end
  endtask

  task automatic test_exit_on_expiry();
    int halt_at;
    assert_reset();
    release_reset();
    run_to_halt(MAXC - 1, 32'd7, halt_at);
    checks += 2;
    if (halt_at != MAXC + DRAIN) begin errors++; $display("[TB] FAIL expiry_halt_cycle got=%0d exp=%0d", halt_at, MAXC + DRAIN); end
    if (bus.ret_val !== 32'd7) begin errors++; $display("[TB] FAIL expiry_ret_val got=%h exp=%h", bus.ret_val, 32'd7); end
  endtask

  task automatic test_ignored_stores();
    int pops;
    int halt_at;
    pops    = 0;
    halt_at = -1;
    assert_reset();
    release_reset();
    set_in(1'b1, CONS_A, 32'h11, 1'b0); @(negedge clk);
    set_in(1'b1, CONS_A, 32'h22, 1'b0); @(negedge clk);
    set_in(1'b1, EXIT_A, 32'h1234_5678, 1'b0); @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, (k % 2 == 0) ? CONS_A : EXIT_A, $urandom, 1'b0);
      #1;
      checks += 2;
      if (bus.wr_stall !== 1'b0) begin errors++; $display("[TB] FAIL drain_stall%0d got=%b exp=0", k, bus.wr_stall); end
      if (bus.ret_val !== 32'h1234_5678) begin errors++; $display("[TB] FAIL drain_ret%0d got=%h exp=12345678", k, bus.ret_val); end
      @(negedge clk);
    end
    for (int k = 0; k < 30 && halt_at < 0; k++) begin
      set_in(1'b1, CONS_A, $urandom, 1'b1);
      #1;
      if (bus.cons_valid && bus.cons_ready) pops++;
      if (bus.isHalt === 1'b1) halt_at = cycle_no;
      @(negedge clk);
    end
    checks += 2;
    if (pops != 2) begin errors++; $display("[TB] FAIL drain_pops got=%0d exp=2", pops); end
    if (halt_at < 0) begin errors++; $display("[TB] FAIL drain_halt_timeout got=none exp=isHalt"); end
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, (k % 2 == 0) ? CONS_A : EXIT_A, $urandom, 1'b1);
      #1;
      checks += 4;
      if (bus.wr_stall !== 1'b0) begin errors++; $display("[TB] FAIL halt_stall%0d got=%b exp=0", k, bus.wr_stall); end
      if (bus.cons_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_cons_valid%0d got=%b exp=0", k, bus.cons_valid); end
      if (bus.isHalt !== 1'b1) begin errors++; $display("[TB] FAIL halt_level%0d got=%b exp=1", k, bus.isHalt); end
      if (bus.ret_val !== 32'h1234_5678) begin errors++; $display("[TB] FAIL halt_ret%0d got=%h exp=12345678", k, bus.ret_val); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_drain();
    int halt_at;
    assert_reset();
    release_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, CONS_A, 32'hA0 + 32'(k), 1'b0); @(negedge clk);
    end
    set_in(1'b1, EXIT_A, 32'd9, 1'b0); @(negedge clk);
    set_in(1'b0, '0, '0, 1'b0); @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.cons_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_cons_valid got=%b exp=0", bus.cons_valid); end
    if (bus.cons_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_cons_data got=%h exp=0", bus.cons_data); end
    if (bus.isHalt !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_isHalt got=%b exp=0", bus.isHalt); end
    if (bus.ret_val !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_ret_val got=%h exp=0", bus.ret_val); end
    if (bus.wr_stall !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_stall got=%b exp=0", bus.wr_stall); end
    release_reset();
    run_to_halt(0, 32'd1, halt_at);
    checks += 3;
    if (halt_at != 1 + DRAIN) begin errors++; $display("[TB] FAIL mid_rst_halt_cycle got=%0d exp=%0d", halt_at, 1 + DRAIN); end
    if (bus.ret_val !== 32'd1) begin errors++; $display("[TB] FAIL mid_rst_ret_val_after got=%h exp=1", bus.ret_val); end
    if (bus.cons_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_fifo_flushed got=%b exp=0", bus.cons_valid); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic        rdy;
    logic        exp_stall;
    int          a;
    int          stop_at;
    for (int ep = 0; ep < 6; ep++) begin
      assert_reset();
      release_reset();
      stop_at = -1;
      for (int k = 0; k < 160; k++) begin
        a = $urandom_range(0, 99);
        if (a < 60)      addr = CONS_A;
        else if (a < 63) addr = EXIT_A;
        else if (a < 75) addr = CONS_A + 32'd1;
        else if (a < 85) addr = EXIT_A + 32'd1;
        else             addr = $urandom;
        rdy = ($urandom_range(0, 99) < ep * 15 + 10);
        set_in($urandom_range(0, 9) < 8, addr, $urandom, rdy);
        #1;
        exp_stall = !m_stop && bus.wr_en && (bus.wr_addr == CONS_A) && (mq.size() == DEPTH);
        checks += 4;
        if (bus.wr_stall !== exp_stall) begin errors++; $display("[TB] FAIL rnd_stall ep%0d c%0d got=%b exp=%b", ep, k, bus.wr_stall, exp_stall); end
        if (bus.cons_valid !== (mq.size() > 0)) begin errors++; $display("[TB] FAIL rnd_valid ep%0d c%0d got=%b exp=%b", ep, k, bus.cons_valid, mq.size() > 0); end
        if (bus.isHalt !== m_halt) begin errors++; $display("[TB] FAIL rnd_halt ep%0d c%0d got=%b exp=%b", ep, k, bus.isHalt, m_halt); end
        if (bus.ret_val !== m_ret) begin errors++; $display("[TB] FAIL rnd_ret ep%0d c%0d got=%h exp=%h", ep, k, bus.ret_val, m_ret); end
        if (mq.size() > 0) begin
          checks++;
          if (bus.cons_data !== mq[0]) begin errors++; $display("[TB] FAIL rnd_data ep%0d c%0d got=%h exp=%h", ep, k, bus.cons_data, mq[0]); end
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_halt && stop_at < 0) stop_at = k;
        if (stop_at >= 0 && k > stop_at + 3) break;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    set_in(1'b0, '0, '0, 1'b0);
    model_reset();
    test_reset();
    test_hello();
    test_fifo_full();
    test_watchdog();
    test_exit_on_expiry();
    test_ignored_stores();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
